// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state encoding and bit-counter sizing for serial_add.
package serial_add_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/serial_add_full_add_cell.sv
// full_add_cell: combinational full adder built from two half-adder stages and an OR.
module full_add_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s1, c1, c2;
  assign s1 = a ^ b;
  assign c1 = a & b;
  assign s  = s1 ^ ci;
  assign c2 = s1 & ci;
  assign co = c1 | c2;
endmodule

// File: rtl/serial_add.sv
// serial_add: bit-serial LSB-first ripple adder, one bit per clock through a single full-adder cell.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_add
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = cnt_w(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d, acc_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, cout_q, cout_d, done_q, done_d, s_bit, c_bit, last;
`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif
  full_add_cell u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (c_q),
    .s  (s_bit),
    .co (c_bit)
  );
  // Sum bits enter at the MSB so the word is in place after WIDTH shifts.
  assign acc_nx = (acc_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign sum    = sum_q;
  assign cout   = cout_q;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (state_q == IDLE) begin
      if (start) begin
        a_d     = a;
        b_d     = b;
        c_d     = cin;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
    end else begin
      acc_d = acc_nx;
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      c_d   = c_bit;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        sum_d   = acc_nx;
        cout_d  = c_bit;
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = c_q ^ c_bit;
`endif
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
endmodule

// File: tb/tb_serial_add.sv
// tb_serial_add: three serial_add instances (WIDTH 8, 1, 16) checked against a behavioural model plus literal cases.
module tb_serial_add;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic st[3];
  logic [15:0] av[3], bv[3];
  logic ci[3];
  logic busy_o[3], done_o[3], cout_o[3];
  logic [7:0] sum8;
  logic [0:0] sum1;
  logic [15:0] sum16;
`ifdef SERIAL_ADD_OVF_EN
  logic ovf_o[3];
`endif
  int errors = 0;
  int checks = 0;
  serial_add #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0][7:0]), .b(bv[0][7:0]), .cin(ci[0]),
    .busy(busy_o[0]), .done(done_o[0]), .sum(sum8), .cout(cout_o[0])
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf_o[0])
`endif
  );
  serial_add #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1][0:0]), .b(bv[1][0:0]), .cin(ci[1]),
    .busy(busy_o[1]), .done(done_o[1]), .sum(sum1), .cout(cout_o[1])
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf_o[1])
`endif
  );
  serial_add #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .a(av[2]), .b(bv[2]), .cin(ci[2]),
    .busy(busy_o[2]), .done(done_o[2]), .sum(sum16), .cout(cout_o[2])
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf_o[2])
`endif
  );
  function automatic int w_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 1 : 16;
  endfunction
  // Exact result of x+y+c at width w: {signed overflow, carry out, sum}.
  function automatic logic [17:0] ref_add(input int w, input int x0, input int y0, input int c);
    int m, x, y, t, sx, sy, s;
    logic [17:0] r;
    m  = (1 << w) - 1;
    x  = x0 & m;
    y  = y0 & m;
    t  = x + y + c;
    sx = (x >= (1 << (w - 1))) ? x - (1 << w) : x;
    sy = (y >= (1 << (w - 1))) ? y - (1 << w) : y;
    s  = sx + sy + c;
    r[15:0] = 16'(t & m);
    r[16]   = ((t >> w) & 1) != 0;
    r[17]   = (s > (m >> 1)) || (s < -(1 << (w - 1)));
    return r;
  endfunction
  function automatic logic [31:0] sum_of(input int k);
    return (k == 0) ? {24'b0, sum8} : (k == 1) ? {31'b0, sum1} : {16'b0, sum16};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  bit mb[3], md[3];
  int rem[3];
  logic [17:0] pend[3], outv[3];
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        mb[k] = 0; md[k] = 0; rem[k] = 0; outv[k] = '0; pend[k] = '0;
      end else begin
        md[k] = 0;
        if (mb[k]) begin
          rem[k]--;
          if (rem[k] == 0) begin
            mb[k] = 0; md[k] = 1; outv[k] = pend[k];
          end
        end else if (st[k]) begin
          mb[k] = 1;
          rem[k] = w_of(k);
          pend[k] = ref_add(w_of(k), int'(av[k]), int'(bv[k]), int'(ci[k]));
        end
      end
    end
  end
  always @(posedge clk) begin
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("busy[%0d]", k), 32'(busy_o[k]), 32'(mb[k]));
      chk($sformatf("done[%0d]", k), 32'(done_o[k]), 32'(md[k]));
      chk($sformatf("sum[%0d]", k), sum_of(k), {16'b0, outv[k][15:0]});
      chk($sformatf("cout[%0d]", k), 32'(cout_o[k]), 32'(outv[k][16]));
`ifdef SERIAL_ADD_OVF_EN
      chk($sformatf("ovf[%0d]", k), 32'(ovf_o[k]), 32'(outv[k][17]));
`endif
    end
  end
  task automatic issue(input int k, input int x, input int y, input int c);
    st[k] = 1'b1; av[k] = 16'(x); bv[k] = 16'(y); ci[k] = c[0];
    @(negedge clk);
    st[k] = 1'b0;
  endtask
  task automatic wait_done(input int k, output int n);
    n = 1;
    while (!done_o[k] && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask
  int n, pulses;
  logic [7:0] held;
  initial begin
    for (int k = 0; k < 3; k++) begin
      st[k] = 0; av[k] = '0; bv[k] = '0; ci[k] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o[0]), 0);
    chk("rst_done", 32'(done_o[0]), 0);
    chk("rst_sum", 32'(sum8), 0);
    chk("rst_cout", 32'(cout_o[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, 'hFF, 'h01, 0);
    wait_done(0, n);
    chk("ff01_lat", n, 9);
    chk("ff01_sum", 32'(sum8), 'h00);
    chk("ff01_cout", 32'(cout_o[0]), 1);
`ifdef SERIAL_ADD_OVF_EN
    chk("ff01_ovf", 32'(ovf_o[0]), 0);
`endif
    @(negedge clk);
    issue(0, 'h7F, 'h01, 0);
    wait_done(0, n);
    chk("7f01_sum", 32'(sum8), 'h80);
    chk("7f01_cout", 32'(cout_o[0]), 0);
`ifdef SERIAL_ADD_OVF_EN
    chk("7f01_ovf", 32'(ovf_o[0]), 1);
`endif
    @(negedge clk);
    issue(0, 'h00, 'h00, 1);
    wait_done(0, n);
    chk("cin_sum", 32'(sum8), 'h01);
    chk("cin_cout", 32'(cout_o[0]), 0);
    @(negedge clk);
    issue(0, 'h12, 'h34, 0);
    @(negedge clk);
    st[0] = 1; av[0] = 16'hFF; bv[0] = 16'hFF; ci[0] = 1;
    repeat (3) @(negedge clk);
    st[0] = 0;
    pulses = 0;
    held = 8'h00;
    repeat (12) begin
      if (done_o[0]) begin
        pulses++;
        held = sum8;
      end
      @(negedge clk);
    end
    chk("busy_start_pulses", pulses, 1);
    chk("busy_start_sum", 32'(held), 'h46);
    issue(0, 'h01, 'h02, 0);
    wait_done(0, n);
    chk("pre_b2b_sum", 32'(sum8), 'h03);
    issue(0, 'h10, 'h20, 0);
    wait_done(0, n);
    chk("b2b_lat", n, 9);
    chk("b2b_sum", 32'(sum8), 'h30);
    @(negedge clk);
    issue(0, 'hAA, 'h55, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy_o[0]), 0);
    chk("mid_rst_done", 32'(done_o[0]), 0);
    chk("mid_rst_sum", 32'(sum8), 0);
    chk("mid_rst_cout", 32'(cout_o[0]), 0);
    pulses = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      pulses += int'(done_o[0]);
    end
    chk("mid_rst_no_done", pulses, 0);
    issue(0, 'hAA, 'h55, 0);
    wait_done(0, n);
    chk("after_rst_lat", n, 9);
    chk("after_rst_sum", 32'(sum8), 'hFF);
    chk("after_rst_cout", 32'(cout_o[0]), 0);
    issue(1, 1, 1, 1);
    wait_done(1, n);
    chk("w1_lat", n, 2);
    chk("w1_sum", 32'(sum1), 1);
    chk("w1_cout", 32'(cout_o[1]), 1);
`ifdef SERIAL_ADD_OVF_EN
    chk("w1_ovf", 32'(ovf_o[1]), 0);
`endif
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(2, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), int'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        st[2] = 1; av[2] = 16'($urandom); bv[2] = 16'($urandom);
        @(negedge clk);
        st[2] = 0;
      end
      wait_done(2, n);
      chk("rnd_timeout", 32'(n < 60), 1);
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
